// File: rtl/la_uart_tx.sv
// UART transmitter for the analyzer host link: a small circular byte FIFO
// feeding an 8N1 (optionally 8E1) serializer, LSB first, with a registered line output.
module la_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TLOAD = TW'(CLK_DIV - 1);
  localparam logic [PW:0]   FULL  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_tx;

  logic w_ready;
  logic w_nonempty;
  logic w_push;
  logic w_bit_done;
  logic w_pop;

  assign w_ready    = (r_count != FULL);
  assign w_nonempty = (r_count != '0);
  assign w_push     = in_valid && w_ready;
  assign w_bit_done = (r_timer == '0);
  // The head is taken either from idle or on the last stop cycle, so frames chain with no gap.
  assign w_pop      = w_nonempty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (in_valid && !w_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // r_tx is loaded with the level of the state being entered, keeping the line glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= TLOAD;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx    <= 1'b1;
          r_timer <= TLOAD;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_par   <= ^r_mem[r_rd_ptr];
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_state <= S_DATA;
            r_idx   <= '0;
            r_timer <= TLOAD;
            r_tx    <= r_shift[0];
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_timer <= TLOAD;
            r_shift <= r_shift >> 1;
            if (r_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_done) begin
            r_state <= S_STOP;
            r_timer <= TLOAD;
            r_tx    <= 1'b1;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_timer <= TLOAD;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_par   <= ^r_mem[r_rd_ptr];
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= TLOAD;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = w_ready;
  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE) || w_nonempty;
  assign overflow = r_overflow;
  assign level    = r_count;

endmodule

// File: tb/tb_la_uart_tx.sv
// Directed bench for la_uart_tx: four instances cover 8N1 at divide-by-4, 8E1,
// and the divider extremes 2 and 65535; line waveforms are checked bit by bit.
module tb_la_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [7:0] dat [4];
  logic [3:0] rdy;
  logic [3:0] txw;
  logic [3:0] bsy;
  logic [3:0] ovf;
  logic [2:0] lvl [4];

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  la_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .PARITY_EN(0)) u_a (
    .clk(clk), .rst(rst), .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .tx(txw[0]), .busy(bsy[0]), .overflow(ovf[0]), .level(lvl[0]));

  la_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .PARITY_EN(1)) u_b (
    .clk(clk), .rst(rst), .in_data(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .tx(txw[1]), .busy(bsy[1]), .overflow(ovf[1]), .level(lvl[1]));

  la_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .PARITY_EN(0)) u_c (
    .clk(clk), .rst(rst), .in_data(dat[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .tx(txw[2]), .busy(bsy[2]), .overflow(ovf[2]), .level(lvl[2]));

  la_uart_tx #(.CLK_DIV(65535), .FIFO_DEPTH(4), .PARITY_EN(0)) u_d (
    .clk(clk), .rst(rst), .in_data(dat[3]), .in_valid(vld[3]), .in_ready(rdy[3]),
    .tx(txw[3]), .busy(bsy[3]), .overflow(ovf[3]), .level(lvl[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int inst, input logic [7:0] b);
    vld[inst] = 1'b1;
    dat[inst] = b;
    tick();
    vld[inst] = 1'b0;
  endtask

  // Entered while sampling the first start-bit cycle (minus 'skip' cycles already elapsed).
  task automatic frame_check(input int inst, input logic [7:0] b, input int pe,
                             input int div, input int skip, input int nbits,
                             output int bcnt);
    logic [10:0] bits;
    int cnt;
    int expc;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (pe != 0) bits[9] = ^b;
    bcnt = 0;
    for (int i = 0; i < nbits; i++) begin
      cnt  = 0;
      expc = (i == 0) ? div - skip : div;
      for (int c = 0; c < expc; c++) begin
        if (txw[inst] === bits[i]) cnt++;
        if (bsy[inst] === 1'b1) bcnt++;
        tick();
      end
      check($sformatf("inst%0d_byte%02h_bit%0d", inst, b, i), cnt, expc);
    end
    $display("frame inst=%0d byte=%02h bits_checked=%0d busy_cycles=%0d", inst, b, nbits, bcnt);
  endtask

  initial begin
    int bc;
    int bc2;
    rst = 1'b1;
    vld = '0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    tick();
    tick();
    check("rst_tx", txw[0], 1);
    check("rst_ready", rdy[0], 1);
    check("rst_busy", bsy[0], 0);
    check("rst_overflow", ovf[0], 0);
    check("rst_level", lvl[0], 0);
    rst = 1'b0;
    tick();

    // Single byte, 8N1 at divide-by-4
    push1(0, 8'hA5);
    check("a5_busy_after_push", bsy[0], 1);
    check("a5_level_after_push", lvl[0], 1);
    check("a5_tx_high_after_push", txw[0], 1);
    tick();
    check("a5_level_after_pop", lvl[0], 0);
    frame_check(0, 8'hA5, 0, 4, 0, 10, bc);
    check("a5_busy_cycles", bc, 40);
    check("a5_busy_end", bsy[0], 0);
    check("a5_tx_idle", txw[0], 1);

    // Back to back 0x00 then 0xFF
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    tick();
    dat[0] = 8'hFF;
    tick();
    vld[0] = 1'b0;
    check("b2b_level", lvl[0], 1);
    frame_check(0, 8'h00, 0, 4, 0, 10, bc);
    frame_check(0, 8'hFF, 0, 4, 0, 10, bc2);
    check("b2b_busy_cycles", bc + bc2, 80);
    check("b2b_busy_end", bsy[0], 0);

    // Even parity
    push1(1, 8'h07);
    tick();
    frame_check(1, 8'h07, 1, 4, 0, 11, bc);
    check("par07_busy_cycles", bc, 44);
    push1(1, 8'h03);
    tick();
    frame_check(1, 8'h03, 1, 4, 0, 11, bc);
    check("par03_busy_end", bsy[1], 0);

    // Full FIFO and sticky overflow
    vld[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dat[0] = 8'h10 + 8'(i);
      tick();
      if (i == 4) begin
        check("full_ready", rdy[0], 0);
        check("full_level", lvl[0], 4);
        check("full_no_overflow_yet", ovf[0], 0);
      end
    end
    vld[0] = 1'b0;
    check("ovf_set", ovf[0], 1);
    check("ovf_level_kept", lvl[0], 4);
    frame_check(0, 8'h10, 0, 4, 4, 10, bc);
    for (int i = 1; i < 5; i++) begin
      frame_check(0, 8'h10 + 8'(i), 0, 4, 0, 10, bc);
    end
    check("ovf_sticky", ovf[0], 1);
    check("ovf_drain_busy", bsy[0], 0);
    check("ovf_drain_level", lvl[0], 0);

    // Reset during data bit 3 with two bytes queued
    push1(0, 8'hC3);
    tick();
    push1(0, 8'h55);
    push1(0, 8'h66);
    repeat (15) tick();
    check("mid_tx_d3", txw[0], 0);
    check("mid_level", lvl[0], 2);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", txw[0], 1);
    check("mid_rst_busy", bsy[0], 0);
    check("mid_rst_level", lvl[0], 0);
    check("mid_rst_overflow", ovf[0], 0);
    check("mid_rst_ready", rdy[0], 1);
    rst = 1'b0;
    tick();
    push1(0, 8'h3C);
    tick();
    frame_check(0, 8'h3C, 0, 4, 0, 10, bc);
    check("post_rst_busy_end", bsy[0], 0);

    // Divider extremes
    push1(2, 8'h5A);
    tick();
    frame_check(2, 8'h5A, 0, 2, 0, 10, bc);
    check("div2_busy_cycles", bc, 20);
    check("div2_busy_end", bsy[2], 0);

    // Start bit then D0=1 at 65535 makes the first bit boundary observable
    push1(3, 8'hA5);
    tick();
    frame_check(3, 8'hA5, 0, 65535, 0, 1, bc);
    check("div65535_d0_high", txw[3], 1);
    check("div65535_busy", bsy[3], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/la_uart_tx.md
# la_uart_tx

UART transmitter for the logic analyzer's host link: the reverse direction of the UART decoder. It accepts bytes from the analyzer core (decoded protocol bytes, raw samples, detect flags) over a valid/ready handshake and buffers them in a small FIFO. It serializes them as 8-bit UART frames, LSB first, on a single line toward the host, so results leave the chip without occupying `uo_out`.

## Interface
Parameters:
- `CLK_DIV`, default 16: clock cycles per bit; legal range 2..65535.
- `FIFO_DEPTH`, default 4: byte buffer entries; must be a power of two, at least 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between D7 and the stop bit.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` is offered this cycle.
- `in_ready`  out  1  FIFO not full; a byte is accepted on an edge where `in_valid && in_ready`.
- `tx`  out  1  serial line; idles high; registered output.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `overflow`  out  1  sticky; set when `in_valid && !in_ready`; cleared only by `rst`.
- `level`  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- FIFO is circular with read and write pointers and a count of 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- `in_ready` = (count != FIFO_DEPTH), decoded from the registered count.
- Push and pop in the same cycle leave the count unchanged.
- A push is never accepted while the FIFO is full, even if a pop happens in that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If count>0, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLK_DIV cycles, then shift right and increment the index. After index 7 completes, go to PARITY if PARITY_EN, otherwise STOP.
  - PARITY: `tx`=XOR of the 8 data bits (even parity) for CLK_DIV cycles, then go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. On the final cycle, if count>0, pop and go directly to START so frames run back to back with no idle gap. Otherwise go to IDLE.
- Bit timer: counts down from CLK_DIV-1 to 0. It is reloaded on every state entry and every bit advance. Its width is clog2(CLK_DIV).
- `overflow` sets on any cycle with `in_valid && !in_ready`. The offered byte is dropped and the FIFO contents are unaffected.
- `busy` = (state != IDLE) || (count != 0).

## Timing
- Reset values: `tx`=1, `in_ready`=1, `busy`=0, `overflow`=0, `level`=0, FSM=IDLE, pointers=0. The shift register is cleared.
- Reset mid-frame: on the next edge, `tx` returns to 1 and the FIFO is flushed. The partial frame is truncated, with no stop-bit completion.
- Latency: a byte pushed into an empty FIFO while IDLE on edge E0 is popped on edge E1. `tx` falls after E1, so it is first low in the cycle following E1.
- Frame length: (10 + PARITY_EN) × CLK_DIV cycles.
- Back to back: the next start bit begins exactly CLK_DIV cycles after the stop bit begins.
- `level` and `in_ready` update on the edge after a push or pop. A pop frees a slot that can be used on the following edge.
- `busy` falls on the edge where STOP exits to IDLE with count 0.

## Test plan
- Single byte: CLK_DIV=4, PARITY_EN=0, push 0xA5 once.
  - `tx` goes low one cycle after the push and stays low 4 cycles.
  - Data bits then follow: 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 high cycles.
  - `busy` is high for exactly 40 cycles.
- Back to back: push 0x00 then 0xFF on consecutive cycles.
  - The 0xFF start bit follows the 0x00 stop bit with no extra idle cycle.
  - Total `busy` time is 80 cycles at CLK_DIV=4.
- Parity: PARITY_EN=1, push 0x07.
  - The parity bit is 1 and the frame is 44 cycles at CLK_DIV=4.
  - Push 0x03: the parity bit is 0.
- Full and overflow: FIFO_DEPTH=4, hold `in_valid` high with bytes 0x10..0x15.
  - The first byte is popped, so 5 bytes are accepted, then `in_ready`=0.
  - The sixth byte is dropped and `overflow` goes to 1 and stays there.
  - The transmitted order is 0x10..0x14.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - On the next edge, `tx`=1, `busy`=0 and `level`=0.
  - A byte pushed after reset is transmitted as a complete, correct frame.
- Divider extremes: with CLK_DIV=2 and with CLK_DIV=65535, push 0x5A. Every bit lasts exactly CLK_DIV cycles.
